// File: rtl/cpu_bus_arbiter_if.sv
// Shared memory-bus side of cpu_bus_arbiter: strobes, address/data, completions and busy flags.
// The arbiter uses the master modport; the memory/dispatcher side uses the slave modport.
interface cpu_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              read_q;
  logic              write_q;
  logic [DATA_W-1:0] data_in;
  logic              read_dn;
  logic              write_dn;
  logic              bus_busy_in;
  logic              bus_busy_out;

  modport master (
    output addr_out,
    output data_out,
    output read_q,
    output write_q,
    output bus_busy_out,
    input  data_in,
    input  read_dn,
    input  write_dn,
    input  bus_busy_in
  );

  modport slave (
    input  addr_out,
    input  data_out,
    input  read_q,
    input  write_q,
    input  bus_busy_out,
    output data_in,
    output read_dn,
    output write_dn,
    output bus_busy_in
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter putting CHANNELS cores onto one external memory bus, one transaction at a time.
// Define ARB_TIMEOUT_EN to build the BUSY watchdog (TIMEOUT cycles, err pulse); err is tied 0 otherwise.
module cpu_bus_arbiter #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          ch_read_q,
  input  logic [CHANNELS-1:0]          ch_write_q,
  input  logic [CHANNELS*ADDR_W-1:0]   ch_addr,
  input  logic [CHANNELS*DATA_W-1:0]   ch_data,
  output logic [CHANNELS-1:0]          ch_read_dn,
  output logic [CHANNELS-1:0]          ch_write_dn,
  output logic [DATA_W-1:0]            ch_data_out,
  output logic [3:0]                   grant_idx,
  output logic                         err,
  cpu_bus_arbiter_if.master            bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          rr_ptr_q, rr_ptr_d;
  logic [3:0]          grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CHANNELS-1:0] rd_dn_q, rd_dn_d;
  logic [CHANNELS-1:0] wr_dn_q, wr_dn_d;

  logic [CHANNELS-1:0] req;
  logic                any_req, hi_found;
  logic [3:0]          hi_idx, lo_idx, sel_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_wr;
  logic                grant_go, done_ok, tmo;
  logic [CHANNELS-1:0] grant_oh;

  assign req = ch_read_q | ch_write_q;

  // Lowest requester at/after rr_ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = int'(CHANNELS) - 1; j >= 0; j--) begin
      if (req[j]) begin
        any_req = 1'b1;
        lo_idx  = 4'(j);
        if (4'(j) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = 4'(j);
        end
      end
    end
    sel_idx  = hi_found ? hi_idx : lo_idx;
    sel_addr = '0;
    sel_data = '0;
    sel_wr   = 1'b0;
    for (int j = 0; j < int'(CHANNELS); j++) begin
      if (4'(j) == sel_idx) begin
        sel_addr = ch_addr[j*ADDR_W +: ADDR_W];
        sel_data = ch_data[j*DATA_W +: DATA_W];
        sel_wr   = ch_write_q[j];
      end
    end
  end

  assign grant_go = (state_q == StIdle) && any_req && !bus.bus_busy_in;
  // Only a completion matching the open strobe closes the transaction.
  assign done_ok  = (state_q == StBusy) &&
                    ((wr_q && bus.write_dn) || (rd_q && bus.read_dn));
  assign grant_oh = CHANNELS'(1) << grant_q;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == StBusy) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tmo   = (state_q == StBusy) && !done_ok && (cnt_q == CntW'(TIMEOUT - 1));
  assign err_d = tmo;
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo            = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      rd_dn_q  <= '0;
      wr_dn_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      rd_dn_q  <= rd_dn_d;
      wr_dn_q  <= wr_dn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_go) state_d = StBusy;
      StBusy:  if (done_ok || tmo) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    rd_dn_d  = '0;
    wr_dn_d  = '0;
    if (grant_go) begin
      // A simultaneous read on the winning channel waits for a later arbitration.
      grant_d  = sel_idx;
      addr_d   = sel_addr;
      data_d   = sel_data;
      wr_d     = sel_wr;
      rd_d     = !sel_wr;
      rr_ptr_d = (sel_idx == 4'(CHANNELS - 1)) ? 4'd0 : sel_idx + 4'd1;
    end
    if (done_ok || tmo) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      rdata_d = tmo ? '0 : bus.data_in;
      if (rd_q) rd_dn_d = grant_oh;
      if (wr_q) wr_dn_d = grant_oh;
    end
  end

  always_comb begin
    bus.addr_out     = addr_q;
    bus.data_out     = data_q;
    bus.read_q       = rd_q;
    bus.write_q      = wr_q;
    bus.bus_busy_out = (state_q == StBusy);
    grant_idx        = grant_q;
    ch_read_dn       = rd_dn_q;
    ch_write_dn      = wr_dn_q;
    ch_data_out      = rdata_q;
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level round-robin model.
module tb_cpu_bus_arbiter;
  localparam int unsigned CH  = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     ch_read_q, ch_write_q;
  logic [CH*AW-1:0]  ch_addr;
  logic [CH*DW-1:0]  ch_data;
  logic [CH-1:0]     ch_read_dn, ch_write_dn;
  logic [DW-1:0]     ch_data_out;
  logic [3:0]        grant_idx;
  logic              err;

  cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cpu_bus_arbiter #(
    .CHANNELS (CH),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_read_q   (ch_read_q),
    .ch_write_q  (ch_write_q),
    .ch_addr     (ch_addr),
    .ch_data     (ch_data),
    .ch_read_dn  (ch_read_dn),
    .ch_write_dn (ch_write_dn),
    .ch_data_out (ch_data_out),
    .grant_idx   (grant_idx),
    .err         (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Model: pending requests per core and the round-robin pointer.
  bit          m_rd [CH];
  bit          m_wr [CH];
  logic [AW-1:0] m_addr [CH];
  logic [DW-1:0] m_wdata [CH];
  int          m_ptr;
  int          checks = 0;
  int          failures = 0;
  int          last_gc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < CH; i++) begin
      ch_read_q[i]           = m_rd[i];
      ch_write_q[i]          = m_wr[i];
      ch_addr[i*AW +: AW]    = m_addr[i];
      ch_data[i*DW +: DW]    = m_wdata[i];
    end
  endtask

  task automatic pick(output int g, output bit w);
    g = -1;
    w = 1'b0;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (m_ptr + k) % CH;
      if (g < 0 && (m_wr[c] || m_rd[c])) begin
        g = c;
        w = m_wr[c];
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < CH; i++) begin
      m_rd[i] = 1'b0;
      m_wr[i] = 1'b0;
    end
  endtask

  task automatic one_txn(input int lat, input logic [DW-1:0] rdata, input bit chk_gap,
                         input bit spur);
    int g;
    bit w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [CH-1:0] oh;
    pick(g, w);
    if (g < 0) begin
      check("model_has_request", 0, 1);
      return;
    end
    ea = m_addr[g];
    ed = m_wdata[g];
    oh = '0;
    oh[g] = 1'b1;
    drive();
    @(posedge clk);
    #1;
    m_ptr = (g + 1) % CH;
    check("grant_idx", grant_idx, g);
    check("strobe_on_grant", {bus.write_q, bus.read_q}, w ? 2'b10 : 2'b01);
    check("addr_out", bus.addr_out, ea);
    if (w) check("data_out", bus.data_out, ed);
    check("busy_out_high", bus.bus_busy_out, 1);
    if (chk_gap) check("grant_gap", cycle - last_gc, 3);
    last_gc = cycle;
    // Perturb the core side while BUSY: address must not be re-sampled, drop must not abort.
    m_addr[g] = ~ea;
    if ($urandom_range(0, 2) == 0) begin
      if (w) m_wr[g] = 1'b0;
      else   m_rd[g] = 1'b0;
    end
    drive();
    if (spur) begin
      bus.read_dn  = w;
      bus.write_dn = !w;
      @(posedge clk);
      #1;
      bus.read_dn  = 1'b0;
      bus.write_dn = 1'b0;
      check("mismatched_dn_ignored", {bus.write_q, bus.read_q}, w ? 2'b10 : 2'b01);
      check("mismatched_dn_no_pulse", ch_read_dn | ch_write_dn, 0);
    end
    repeat (lat) begin
      @(posedge clk);
      #1;
      check("strobe_held", {bus.write_q, bus.read_q}, w ? 2'b10 : 2'b01);
    end
    check("addr_stable", bus.addr_out, ea);
    bus.data_in = rdata;
    if (w) bus.write_dn = 1'b1;
    else   bus.read_dn  = 1'b1;
    @(posedge clk);
    #1;
    bus.read_dn  = 1'b0;
    bus.write_dn = 1'b0;
    bus.data_in  = $urandom;
    check("strobe_dropped", {bus.write_q, bus.read_q}, 0);
    check("busy_out_low", bus.bus_busy_out, 0);
    check("ch_write_dn", ch_write_dn, w ? oh : '0);
    check("ch_read_dn", ch_read_dn, w ? '0 : oh);
    if (!w) check("ch_data_out", ch_data_out, rdata);
    check("err_quiet", err, 0);
    if (w) m_wr[g] = 1'b0;
    else   m_rd[g] = 1'b0;
    drive();
    @(posedge clk);
    #1;
    check("dn_single_cycle", ch_read_dn | ch_write_dn, 0);
  endtask

  task automatic busy_hold(input int n);
    bus.bus_busy_in = 1'b1;
    drive();
    repeat (n) begin
      bus.read_dn  = 1'($urandom_range(0, 1));
      bus.write_dn = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("busy_in_blocks_grant", {bus.write_q, bus.read_q}, 0);
      check("idle_dn_ignored", ch_read_dn | ch_write_dn, 0);
    end
    bus.read_dn     = 1'b0;
    bus.write_dn    = 1'b0;
    bus.bus_busy_in = 1'b0;
  endtask

  task automatic add_random();
    bit any;
    for (int i = 0; i < CH; i++) begin
      if (!m_rd[i] && !m_wr[i] && $urandom_range(0, 1) == 1) begin
        int kind;
        kind       = $urandom_range(1, 3);
        m_wr[i]    = kind[0];
        m_rd[i]    = kind[1];
        m_addr[i]  = $urandom;
        m_wdata[i] = $urandom;
      end
    end
    if ($urandom_range(0, 4) == 0) begin
      int c;
      c = $urandom_range(0, CH - 1);
      m_rd[c] = 1'b0;
      m_wr[c] = 1'b0;
    end
    any = 1'b0;
    for (int i = 0; i < CH; i++) any |= m_rd[i] | m_wr[i];
    if (!any) begin
      int c;
      c = $urandom_range(0, CH - 1);
      m_wr[c]    = 1'b1;
      m_addr[c]  = $urandom;
      m_wdata[c] = $urandom;
    end
  endtask

  initial begin
    int g;
    rst_n           = 1'b0;
    bus.data_in     = '0;
    bus.read_dn     = 1'b0;
    bus.write_dn    = 1'b0;
    bus.bus_busy_in = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_addr[i]  = '0;
      m_wdata[i] = '0;
    end
    clear_model();
    m_ptr = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_q", bus.read_q, 0);
    check("rst_write_q", bus.write_q, 0);
    check("rst_busy_out", bus.bus_busy_out, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_addr_out", bus.addr_out, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_dn", {ch_read_dn, ch_write_dn}, 0);
    check("rst_ch_data_out", ch_data_out, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // All four cores write from reset: grants 0,1,2,3 three cycles apart.
    for (int i = 0; i < CH; i++) begin
      m_wr[i]    = 1'b1;
      m_addr[i]  = 32'h1000 + 32'(i * 4);
      m_wdata[i] = $urandom;
    end
    for (int i = 0; i < CH; i++) one_txn(0, '0, i > 0, 1'b0);
    // Pointer wrapped: ch0 beats ch3.
    m_rd[3] = 1'b1;
    m_wr[0] = 1'b1;
    one_txn(0, 32'h0303_0303, 1'b0, 1'b0);
    check("wrap_grant_ch0_first", m_rd[3], 1);
    one_txn(1, 32'h3333_3333, 1'b0, 1'b0);

    m_rd[2]   = 1'b1;
    m_addr[2] = 32'h100;
    one_txn(2, 32'hDEADBEEF, 1'b0, 1'b0);

    // Same-cycle read and write on ch1: write first, read next.
    m_rd[1]    = 1'b1;
    m_wr[1]    = 1'b1;
    m_addr[1]  = 32'h200;
    m_wdata[1] = 32'hCAFE_0001;
    one_txn(0, '0, 1'b0, 1'b0);
    check("read_still_pending", {m_rd[1], m_wr[1]}, 2'b10);
    one_txn(1, 32'h1234_5678, 1'b0, 1'b0);

    m_wr[0]   = 1'b1;
    m_addr[0] = 32'h40;
    busy_hold(10);
    one_txn(0, '0, 1'b0, 1'b0);

    // Reset during BUSY: strobe and busy drop asynchronously, no completion pulse.
    m_rd[2] = 1'b1;
    drive();
    @(posedge clk);
    #1;
    check("pre_reset_strobe", bus.read_q, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_read_q", bus.read_q, 0);
    check("async_rst_write_q", bus.write_q, 0);
    check("async_rst_busy", bus.bus_busy_out, 0);
    clear_model();
    m_ptr = 0;
    drive();
    @(posedge clk);
    #1;
    check("rst_no_dn", {ch_read_dn, ch_write_dn}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_rst", {bus.write_q, bus.read_q, bus.bus_busy_out}, 0);
    m_wr[3] = 1'b1;
    one_txn(0, '0, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      add_random();
      if ($urandom_range(0, 3) == 0) busy_hold($urandom_range(1, 4));
      one_txn($urandom_range(0, 3), $urandom, 1'b0, $urandom_range(0, 3) == 0);
    end

    // No completion from the bus.
    clear_model();
    g = $urandom_range(0, CH - 1);
    m_wr[g] = 1'b1;
    drive();
    @(posedge clk);
    #1;
    check("stall_grant", grant_idx, g);
`ifdef ARB_TIMEOUT_EN
    begin
      bit seen;
      logic [CH-1:0] oh;
      oh = '0;
      oh[g] = 1'b1;
      seen = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        #1;
        if (!seen && (err || ch_write_dn != '0)) begin
          seen = 1'b1;
          check("timeout_cycle", k, TMO);
          check("timeout_err", err, 1);
          check("timeout_dn", ch_write_dn, oh);
          check("timeout_data", ch_data_out, 0);
          check("timeout_strobe", bus.write_q, 0);
        end
      end
      if (!seen) check("timeout_seen", 0, 1);
    end
`else
    begin
      int held;
      held = 0;
      repeat (120) begin
        @(posedge clk);
        #1;
        if (bus.write_q && bus.bus_busy_out && ch_write_dn == '0 && !err) held++;
      end
      check("stall_strobe_held", held, 120);
      bus.write_dn = 1'b1;
      @(posedge clk);
      #1;
      bus.write_dn = 1'b0;
      check("stall_release_dn", ch_write_dn, CH'(1) << g);
    end
`endif
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("final_idle", {bus.write_q, bus.read_q, bus.bus_busy_out}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
